// File: rtl/jogo_sequencia_param_if.sv
// Port bundle of the sequence-memory game core.
// master drives the player side, slave is the game core.
interface jogo_sequencia_param_if #(
  parameter int N_BOTOES = 4
);
  logic                jogar;
  logic                dificuldade;
  logic [15:0]         semente;
  logic [N_BOTOES-1:0] botoes;
  logic [N_BOTOES-1:0] leds;
  logic                ganhou;
  logic                perdeu;
  logic                timeout;
  logic                pronto;
  logic [3:0]          db_estado;
  logic [5:0]          db_rodada;
  logic [5:0]          db_jogada;

  modport master (
    output jogar, dificuldade, semente, botoes,
    input  leds, ganhou, perdeu, timeout, pronto,
    input  db_estado, db_rodada, db_jogada
  );

  modport slave (
    input  jogar, dificuldade, semente, botoes,
    output leds, ganhou, perdeu, timeout, pronto,
    output db_estado, db_rodada, db_jogada
  );
endinterface

// File: rtl/jogo_sequencia_param.sv
// Sequence-memory game core: LFSR sequence, LED display, press checking.
// Define JOGO_REPETE_EN to grant one replay of the round per game.
module jogo_sequencia_param #(
  parameter int N_BOTOES     = 4,
  parameter int PROFUNDIDADE = 16,
  parameter int LIMITE_FACIL = 8,
  parameter int T_MOSTRA     = 1000,
  parameter int T_PAUSA      = 500,
  parameter int T_TIMEOUT    = 5000
) (
  input logic clock,
  input logic reset,
  jogo_sequencia_param_if.slave bus
);
  localparam int LG    = (N_BOTOES > 1) ? $clog2(N_BOTOES) : 1;
  localparam int T_MP  = (T_MOSTRA > T_PAUSA) ? T_MOSTRA : T_PAUSA;
  localparam int T_MAX = (T_MP > T_TIMEOUT) ? T_MP : T_TIMEOUT;
  localparam int TW    = $clog2(T_MAX + 1);

  localparam logic [3:0] INICIAL     = 4'h0;
  localparam logic [3:0] PREPARA     = 4'h1;
  localparam logic [3:0] PAUSA       = 4'h2;
  localparam logic [3:0] MOSTRA      = 4'h3;
  localparam logic [3:0] ESPERA      = 4'h4;
  localparam logic [3:0] REGISTRA    = 4'h5;
  localparam logic [3:0] COMPARA     = 4'h6;
  localparam logic [3:0] PROX_JOGADA = 4'h7;
  localparam logic [3:0] PROX_RODADA = 4'h8;
  localparam logic [3:0] GANHOU      = 4'h9;
  localparam logic [3:0] PERDEU      = 4'hA;

  localparam logic [TW-1:0] FIM_PAUSA  = TW'(T_PAUSA - 1);
  localparam logic [TW-1:0] FIM_MOSTRA = TW'(T_MOSTRA - 1);
  localparam logic [TW-1:0] FIM_ESPERA = TW'(T_TIMEOUT - 1);
  localparam logic [6:0]    LIM_DIF    = 7'(PROFUNDIDADE);
  localparam logic [6:0]    LIM_FAC    = 7'(LIMITE_FACIL);

  logic [3:0]          est_q, est_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [15:0]         seed_q, seed_d;
  logic [6:0]          lim_q, lim_d;
  logic [5:0]          rod_q, rod_d;
  logic [5:0]          idx_q, idx_d;
  logic [N_BOTOES-1:0] jog_q, jog_d;
  logic                to_q, to_d;
`ifdef JOGO_REPETE_EN
  logic                chance_q, chance_d;
`endif
  logic                jogar_q, any_q;

  logic [15:0]         lfsr_nx;
  logic [N_BOTOES-1:0] elem;
  logic                ini, press, mais, vence, acerto;
  logic                falha, por_tempo;

  assign lfsr_nx = {lfsr_q[14:0],
                    lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign elem    = N_BOTOES'(1) << lfsr_q[LG-1:0];
  assign ini     = bus.jogar & ~jogar_q;
  assign press   = (|bus.botoes) & ~any_q;
  assign mais    = idx_q < rod_q;
  assign vence   = ({1'b0, rod_q} + 7'd1) == lim_q;
  assign acerto  = jog_q == elem;

  always_comb begin
    est_d     = est_q;
    tmr_d     = '0;
    lfsr_d    = lfsr_q;
    seed_d    = seed_q;
    lim_d     = lim_q;
    rod_d     = rod_q;
    idx_d     = idx_q;
    jog_d     = jog_q;
    to_d      = to_q;
    falha     = 1'b0;
    por_tempo = 1'b0;
`ifdef JOGO_REPETE_EN
    chance_d  = chance_q;
`endif
    case (est_q)
      INICIAL, GANHOU, PERDEU:
        if (ini) begin
          est_d  = PREPARA;
          seed_d = (bus.semente == 16'h0) ? 16'hACE1 : bus.semente;
          lim_d  = bus.dificuldade ? LIM_DIF : LIM_FAC;
        end
      PREPARA: begin
        est_d    = PAUSA;
        lfsr_d   = seed_q;
        rod_d    = '0;
        idx_d    = '0;
        to_d     = 1'b0;
`ifdef JOGO_REPETE_EN
        chance_d = 1'b1;
`endif
      end
      PAUSA:
        if (tmr_q == FIM_PAUSA) est_d = MOSTRA;
        else tmr_d = tmr_q + 1'b1;
      MOSTRA:
        if (tmr_q != FIM_MOSTRA) begin
          tmr_d = tmr_q + 1'b1;
        end else if (mais) begin
          est_d  = PAUSA;
          idx_d  = idx_q + 6'd1;
          lfsr_d = lfsr_nx;
        end else begin
          est_d  = ESPERA;
          idx_d  = '0;
          lfsr_d = seed_q;
        end
      ESPERA:
        if (press) begin
          est_d = REGISTRA;
        end else if (tmr_q == FIM_ESPERA) begin
          falha     = 1'b1;
          por_tempo = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      REGISTRA: begin
        est_d = COMPARA;
        jog_d = bus.botoes;
      end
      COMPARA:
        unique case (1'b1)
          !acerto:                  falha = 1'b1;
          acerto && mais:           est_d = PROX_JOGADA;
          acerto && !mais && vence: est_d = GANHOU;
          default:                  est_d = PROX_RODADA;
        endcase
      PROX_JOGADA: begin
        est_d  = ESPERA;
        idx_d  = idx_q + 6'd1;
        lfsr_d = lfsr_nx;
      end
      PROX_RODADA: begin
        est_d  = PAUSA;
        rod_d  = rod_q + 6'd1;
        idx_d  = '0;
        lfsr_d = seed_q;
      end
      default: est_d = INICIAL;
    endcase
    if (falha) begin
`ifdef JOGO_REPETE_EN
      // first failure replays the round from its first element
      if (chance_q) begin
        chance_d = 1'b0;
        est_d    = PAUSA;
        idx_d    = '0;
        lfsr_d   = seed_q;
      end else begin
        est_d = PERDEU;
        to_d  = por_tempo;
      end
`else
      est_d = PERDEU;
      to_d  = por_tempo;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      est_q    <= INICIAL;
      tmr_q    <= '0;
      lfsr_q   <= '0;
      seed_q   <= '0;
      lim_q    <= '0;
      rod_q    <= '0;
      idx_q    <= '0;
      jog_q    <= '0;
      to_q     <= 1'b0;
`ifdef JOGO_REPETE_EN
      chance_q <= 1'b0;
`endif
    end else begin
      est_q    <= est_d;
      tmr_q    <= tmr_d;
      lfsr_q   <= lfsr_d;
      seed_q   <= seed_d;
      lim_q    <= lim_d;
      rod_q    <= rod_d;
      idx_q    <= idx_d;
      jog_q    <= jog_d;
      to_q     <= to_d;
`ifdef JOGO_REPETE_EN
      chance_q <= chance_d;
`endif
    end
  end

  // edge history keeps sampling through reset so a held level never fires
  always_ff @(posedge clock) begin
    jogar_q <= bus.jogar;
    any_q   <= |bus.botoes;
  end

  assign bus.leds      = (est_q == MOSTRA) ? elem :
                         (est_q == ESPERA) ? bus.botoes : '0;
  assign bus.ganhou    = est_q == GANHOU;
  assign bus.perdeu    = est_q == PERDEU;
  assign bus.pronto    = (est_q == GANHOU) || (est_q == PERDEU);
  assign bus.timeout   = to_q;
  assign bus.db_estado = est_q;
  assign bus.db_rodada = rod_q;
  assign bus.db_jogada = idx_q;
endmodule
